// File: rtl/div_32_seq.sv
// Sequential non-restoring 32-bit divider that borrows the ALU's shared adder_32 for every step.
// Define DIV_SIGNED_EN for signed two's-complement operands; the default build divides unsigned.
module div_32_seq (
  input  logic        in_clk,
  input  logic        in_reset,
  input  logic        in_start,
  input  logic [31:0] in_dividend,
  input  logic [31:0] in_divisor,
  output logic [31:0] out_adder_x,
  output logic [31:0] out_adder_y,
  output logic        out_adder_carry,
  input  logic [31:0] in_adder_sum,
  input  logic        in_adder_carry,
  output logic        out_busy,
  output logic        out_done,
  output logic        out_div_zero,
  output logic [31:0] out_quotient,
  output logic [31:0] out_remainder
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ITER  = 3'd3;
  localparam logic [2:0] S_FIX   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd7;
`ifdef DIV_SIGNED_EN
  localparam logic [2:0] S_NEG_Q = 3'd1;
  localparam logic [2:0] S_NEG_M = 3'd2;
  localparam logic [2:0] S_SGN_Q = 3'd5;
  localparam logic [2:0] S_SGN_R = 3'd6;
`endif

  logic [2:0]  state_q, state_d;
  logic [32:0] a_q, a_d;
  logic [31:0] q_q, q_d;
  logic [31:0] m_q, m_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        dz_q, dz_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
`ifdef DIV_SIGNED_EN
  logic        sign_q_q, sign_q_d;
  logic        sign_r_q, sign_r_d;
`endif
  logic [32:0] s;
  logic        sub;

  always_comb begin
    state_d         = state_q;
    a_d             = a_q;
    q_d             = q_q;
    m_d             = m_q;
    cnt_d           = cnt_q;
    dz_d            = dz_q;
    quot_d          = quot_q;
    rem_d           = rem_q;
`ifdef DIV_SIGNED_EN
    sign_q_d        = sign_q_q;
    sign_r_d        = sign_r_q;
`endif
    out_adder_x     = 32'd0;
    out_adder_y     = 32'd0;
    out_adder_carry = 1'b0;
    s               = {a_q[31:0], q_q[31]};
    sub             = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          if (in_divisor == 32'd0) begin
            q_d     = 32'hFFFF_FFFF;
            a_d     = {1'b0, in_dividend};
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            q_d     = in_dividend;
            m_d     = in_divisor;
            a_d     = 33'd0;
            dz_d    = 1'b0;
            cnt_d   = 6'd0;
`ifdef DIV_SIGNED_EN
            sign_q_d = in_dividend[31] ^ in_divisor[31];
            sign_r_d = in_dividend[31];
            state_d  = S_NEG_Q;
`else
            state_d  = S_ITER;
`endif
          end
        end
      end
`ifdef DIV_SIGNED_EN
      S_NEG_Q: begin
        if (sign_r_q) begin
          out_adder_x     = ~q_q;
          out_adder_carry = 1'b1;
          q_d             = in_adder_sum;
        end
        state_d = S_NEG_M;
      end
      S_NEG_M: begin
        // M still holds the raw divisor here, so its MSB is the divisor sign.
        if (m_q[31]) begin
          out_adder_x     = ~m_q;
          out_adder_carry = 1'b1;
          m_d             = in_adder_sum;
        end
        state_d = S_ITER;
      end
`endif
      S_ITER: begin
        sub             = ~a_q[32];
        out_adder_x     = s[31:0];
        out_adder_y     = sub ? ~m_q : m_q;
        out_adder_carry = sub;
        // 33rd bit of the partial remainder is rebuilt from the 32-bit adder's carry-out.
        a_d             = {s[32] ^ sub ^ in_adder_carry, in_adder_sum};
        q_d             = {q_q[30:0], ~a_d[32]};
        cnt_d           = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (a_q[32]) begin
          out_adder_x = a_q[31:0];
          out_adder_y = m_q;
          a_d[31:0]   = in_adder_sum;
        end
`ifdef DIV_SIGNED_EN
        state_d = S_SGN_Q;
`else
        state_d = S_DONE;
`endif
      end
`ifdef DIV_SIGNED_EN
      S_SGN_Q: begin
        if (sign_q_q) begin
          out_adder_x     = ~q_q;
          out_adder_carry = 1'b1;
          q_d             = in_adder_sum;
        end
        state_d = S_SGN_R;
      end
      S_SGN_R: begin
        if (sign_r_q) begin
          out_adder_x     = ~a_q[31:0];
          out_adder_carry = 1'b1;
          a_d[31:0]       = in_adder_sum;
        end
        state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Visible results only change on entry to DONE; working registers stay private.
    if (state_d == S_DONE && state_q != S_DONE) begin
      quot_d = q_d;
      rem_d  = a_d[31:0];
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q  <= S_IDLE;
      a_q      <= 33'd0;
      q_q      <= 32'd0;
      m_q      <= 32'd0;
      cnt_q    <= 6'd0;
      dz_q     <= 1'b0;
      quot_q   <= 32'd0;
      rem_q    <= 32'd0;
`ifdef DIV_SIGNED_EN
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      q_q      <= q_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      dz_q     <= dz_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
`ifdef DIV_SIGNED_EN
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
`endif
    end
  end

  assign out_busy      = (state_q != S_IDLE);
  assign out_done      = (state_q == S_DONE);
  assign out_div_zero  = dz_q;
  assign out_quotient  = quot_q;
  assign out_remainder = rem_q;

endmodule
